// File: rtl/chipset_data_bus_steer.sv
// Read-data steering and ready generation for the chipset data path.
// Each CPU/DMA read cycle is claimed by the lowest-index selected internal
// source, or falls through to the external bus if no source claims it.
// A claimed cycle waits out the source's minimum wait-state count and then
// its ready. A source that never becomes ready is timed out with an
// open-bus (all ones) value. Every output is registered.
//
// Handshake: a read cycle is open while memory_read_n or io_read_n is low.
// bus_ready low means "hold the cycle, data not yet valid". bus_ready high
// during an open cycle means data_bus_out is valid and the cycle may
// complete. Releasing both strobes ends the cycle, and all outputs go back
// to their idle values on the next edge.
module chipset_data_bus_steer #(
    parameter int NUM_SOURCES    = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int WAIT_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SRC_W         = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              memory_read_n,
    input  logic                              io_read_n,
    input  logic [NUM_SOURCES-1:0]            source_select,
    input  logic [NUM_SOURCES-1:0]            source_ready,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] source_data,
    input  logic [NUM_SOURCES*WAIT_WIDTH-1:0] source_wait_states,
    input  logic [DATA_WIDTH-1:0]             ext_data_in,
    input  logic                              ext_direction_in,
    input  logic                              timeout_clear,
    output logic [DATA_WIDTH-1:0]             data_bus_out,
    output logic                              data_bus_direction,
    output logic                              bus_ready,
    output logic [SRC_W-1:0]                  active_source,
    output logic                              bus_timeout
);

    // Last WAIT count value before the timeout edge; the timeout counter
    // counts WAIT edges, so reaching this value means the next WAIT edge
    // is the TIMEOUT_CYCLES-th one.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRIVE,
        ST_EXT,
        ST_TIMEOUT
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    read_active;
    logic                    read_active_q;
    logic                    read_start;
    logic                    any_select;
    logic [SRC_W-1:0]        sel_idx;
    logic [SRC_W-1:0]        active_q;
    logic [WAIT_WIDTH-1:0]   wait_cnt_q;
    logic [15:0]             to_cnt_q;
    logic                    start_load;
    logic                    set_timeout;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    ready_q;
    logic                    ready_d;
    logic                    dir_q;
    logic                    dir_d;
    logic                    timeout_q;

    logic [DATA_WIDTH-1:0]   src_data [NUM_SOURCES];
    logic [WAIT_WIDTH-1:0]   src_wait [NUM_SOURCES];

    // Unpack the flat source buses into per-source arrays.
    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_unpack
        assign src_data[g] = source_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign src_wait[g] = source_wait_states[g*WAIT_WIDTH +: WAIT_WIDTH];
    end

    assign read_active = ~memory_read_n | ~io_read_n;
    assign read_start  = read_active & ~read_active_q;

    // Fixed-priority encoder: lowest set select index wins.
    always_comb begin
        sel_idx    = '0;
        any_select = |source_select;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (source_select[i]) begin
                sel_idx = SRC_W'(i);
            end
        end
    end

    // Next-state logic, then the registered output values for that state.
    always_comb begin
        state_d     = state_q;
        start_load  = 1'b0;
        set_timeout = 1'b0;
        data_d      = '0;
        ready_d     = 1'b1;
        dir_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (read_start) begin
                    if (any_select) begin
                        state_d    = ST_WAIT;
                        start_load = 1'b1;
                    end else begin
                        state_d = ST_EXT;
                    end
                end
            end
            ST_WAIT: begin
                // An abort outranks completion and timeout; completion
                // outranks a timeout that falls on the same edge.
                if (!read_active) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == '0 && source_ready[active_q]) begin
                    state_d = ST_DRIVE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = ST_TIMEOUT;
                    set_timeout = 1'b1;
                end
            end
            ST_DRIVE, ST_EXT, ST_TIMEOUT: begin
                if (!read_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_WAIT: begin
                ready_d = 1'b0;
            end
            ST_DRIVE: begin
                // Capture on entry only; hold afterwards even if the
                // source changes its data.
                data_d = (state_q == ST_WAIT) ? src_data[active_q] : data_q;
            end
            ST_EXT: begin
                data_d = ext_direction_in ? ext_data_in : '0;
                dir_d  = ext_direction_in;
            end
            ST_TIMEOUT: begin
                data_d = '1;
            end
            default: begin
                data_d  = '0;
                ready_d = 1'b1;
                dir_d   = 1'b0;
            end
        endcase
    end

    // State, strobe history and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            read_active_q <= 1'b0;
            data_q        <= '0;
            ready_q       <= 1'b1;
            dir_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            read_active_q <= read_active;
            data_q        <= data_d;
            ready_q       <= ready_d;
            dir_q         <= dir_d;
        end
    end

    // Per-cycle source latch, wait-state and timeout counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            active_q   <= '0;
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else if (start_load) begin
            active_q   <= sel_idx;
            wait_cnt_q <= src_wait[sel_idx];
            to_cnt_q   <= '0;
        end else if (state_q == ST_WAIT) begin
            if (wait_cnt_q != '0) begin
                wait_cnt_q <= wait_cnt_q - WAIT_WIDTH'(1);
            end
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            timeout_q <= 1'b0;
        end else if (set_timeout) begin
            timeout_q <= 1'b1;
        end else if (timeout_clear) begin
            timeout_q <= 1'b0;
        end
    end

    assign data_bus_out       = data_q;
    assign data_bus_direction = dir_q;
    assign bus_ready          = ready_q;
    assign active_source      = active_q;
    assign bus_timeout        = timeout_q;

endmodule

// File: tb/tb_chipset_data_bus_steer.sv
// Directed bench for chipset_data_bus_steer. The stimulus pushes the
// expected output word for every clock edge into a queue, and a monitor
// pops it and compares half a clock later.
module tb_chipset_data_bus_steer;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int WW = 4;
    localparam int EW = 13; // {data[7:0], ready, direction, active[1:0], timeout}

    logic            clock = 1'b0;
    logic            reset_n;
    logic            memory_read_n;
    logic            io_read_n;
    logic [N-1:0]    source_select;
    logic [N-1:0]    source_ready;
    logic [N*DW-1:0] source_data;
    logic [N*WW-1:0] source_wait_states;
    logic [DW-1:0]   ext_data_in;
    logic            ext_direction_in;
    logic            timeout_clear;
    logic [DW-1:0]   data_bus_out;
    logic            data_bus_direction;
    logic            bus_ready;
    logic [1:0]      active_source;
    logic            bus_timeout;

    logic [EW-1:0]   exp_q[$];
    string           tag_q[$];
    int              n_checks = 0;
    int              n_pass   = 0;

    chipset_data_bus_steer #(
        .NUM_SOURCES(N),
        .DATA_WIDTH(DW),
        .WAIT_WIDTH(WW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .memory_read_n(memory_read_n),
        .io_read_n(io_read_n),
        .source_select(source_select),
        .source_ready(source_ready),
        .source_data(source_data),
        .source_wait_states(source_wait_states),
        .ext_data_in(ext_data_in),
        .ext_direction_in(ext_direction_in),
        .timeout_clear(timeout_clear),
        .data_bus_out(data_bus_out),
        .data_bus_direction(data_bus_direction),
        .bus_ready(bus_ready),
        .active_source(active_source),
        .bus_timeout(bus_timeout)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Driver: queue the expectation for the coming edge, then take the edge.
    task automatic step(input string tag, input logic [7:0] d, input logic r,
                        input logic dir, input logic [1:0] a, input logic t);
        exp_q.push_back({d, r, dir, a, t});
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n, input string tag, input logic [7:0] d,
                         input logic r, input logic dir, input logic [1:0] a,
                         input logic t);
        for (int k = 0; k < n; k++) begin
            step(tag, d, r, dir, a, t);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clock) begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        string         tag;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            got = {data_bus_out, bus_ready, data_bus_direction, active_source, bus_timeout};
            n_checks++;
            if (got !== e) begin
                $display("FAIL %s @%0t: got data=%h rdy=%b dir=%b src=%0d tmo=%b, expected data=%h rdy=%b dir=%b src=%0d tmo=%b",
                         tag, $time, got[12:5], got[4], got[3], got[2:1], got[0],
                         e[12:5], e[4], e[3], e[2:1], e[0]);
            end else begin
                n_pass++;
            end
        end
    end

    // Stimulus
    initial begin
        reset_n            = 1'b0;
        memory_read_n      = 1'b1;
        io_read_n          = 1'b1;
        source_select      = '0;
        source_ready       = '0;
        source_data        = '0;
        source_wait_states = '0;
        ext_data_in        = '0;
        ext_direction_in   = 1'b0;
        timeout_clear      = 1'b0;

        steps(2, "reset", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
        reset_n = 1'b1;
        step("idle", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);

        // Sources 1 and 2 claim; 1 wins, W=3, ready already high.
        source_select      = 4'b0110;
        source_ready       = 4'b0110;
        source_data        = {8'h33, 8'hA5, 8'h5A, 8'h11};
        source_wait_states = 16'h2135;
        memory_read_n      = 1'b0;
        step("prio_start", 8'h00, 1'b0, 1'b0, 2'd1, 1'b0);
        source_select      = 4'b0001;   // late changes must be ignored
        source_wait_states = 16'h2105;
        steps(3, "prio_wait", 8'h00, 1'b0, 1'b0, 2'd1, 1'b0);
        step("prio_drive", 8'h5A, 1'b1, 1'b0, 2'd1, 1'b0);
        source_data[15:8] = 8'h00;     // data must stay latched
        steps(2, "prio_hold", 8'h5A, 1'b1, 1'b0, 2'd1, 1'b0);
        memory_read_n = 1'b1;
        step("prio_idle", 8'h00, 1'b1, 1'b0, 2'd1, 1'b0);

        // No claim: external bus path, active_source held at 1.
        source_select    = 4'b0000;
        ext_direction_in = 1'b0;
        ext_data_in      = 8'h21;
        memory_read_n    = 1'b0;
        step("ext_start", 8'h00, 1'b1, 1'b0, 2'd1, 1'b0);
        ext_direction_in = 1'b1;
        step("ext_21", 8'h21, 1'b1, 1'b1, 2'd1, 1'b0);
        ext_data_in = 8'h22;
        step("ext_22", 8'h22, 1'b1, 1'b1, 2'd1, 1'b0);
        ext_direction_in = 1'b0;
        step("ext_off", 8'h00, 1'b1, 1'b0, 2'd1, 1'b0);
        ext_direction_in = 1'b1;
        ext_data_in      = 8'h7E;
        step("ext_7e", 8'h7E, 1'b1, 1'b1, 2'd1, 1'b0);
        memory_read_n = 1'b1;
        step("ext_idle", 8'h00, 1'b1, 1'b0, 2'd1, 1'b0);
        ext_direction_in = 1'b0;

        // Source 0, W=0, ready arrives late via the I/O strobe.
        source_select      = 4'b0001;
        source_wait_states = 16'h0000;
        source_ready       = 4'b0000;
        source_data[7:0]   = 8'hC3;
        io_read_n          = 1'b0;
        step("late_start", 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        steps(6, "late_wait", 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        source_ready = 4'b0001;
        step("late_drive", 8'hC3, 1'b1, 1'b0, 2'd0, 1'b0);
        io_read_n = 1'b1;
        step("late_idle", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);

        // Abort on the edge that would otherwise time out.
        source_select      = 4'b1000;
        source_wait_states = 16'h3000;
        source_ready       = 4'b0000;
        memory_read_n      = 1'b0;
        step("abort_start", 8'h00, 1'b0, 1'b0, 2'd3, 1'b0);
        steps(7, "abort_wait", 8'h00, 1'b0, 1'b0, 2'd3, 1'b0);
        memory_read_n = 1'b1;
        steps(2, "abort_idle", 8'h00, 1'b1, 1'b0, 2'd3, 1'b0);

        // Ready on the timeout edge: completion wins.
        source_select      = 4'b0001;
        source_wait_states = 16'h0000;
        source_data[7:0]   = 8'h96;
        memory_read_n      = 1'b0;
        step("race_start", 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        steps(7, "race_wait", 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        source_ready = 4'b0001;
        step("race_drive", 8'h96, 1'b1, 1'b0, 2'd0, 1'b0);
        memory_read_n = 1'b1;
        step("race_idle", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);

        // Timeout after 8 WAIT edges, sticky flag, clear.
        source_select      = 4'b0100;
        source_wait_states = 16'h0200;
        source_ready       = 4'b0000;
        memory_read_n      = 1'b0;
        step("to_start", 8'h00, 1'b0, 1'b0, 2'd2, 1'b0);
        steps(7, "to_wait", 8'h00, 1'b0, 1'b0, 2'd2, 1'b0);
        step("to_fire", 8'hFF, 1'b1, 1'b0, 2'd2, 1'b1);
        step("to_hold", 8'hFF, 1'b1, 1'b0, 2'd2, 1'b1);
        memory_read_n = 1'b1;
        step("to_sticky", 8'h00, 1'b1, 1'b0, 2'd2, 1'b1);
        timeout_clear = 1'b1;
        step("to_clear", 8'h00, 1'b1, 1'b0, 2'd2, 1'b0);
        timeout_clear = 1'b0;

        // Second timeout with clear on the same edge: set wins.
        memory_read_n = 1'b0;
        step("to2_start", 8'h00, 1'b0, 1'b0, 2'd2, 1'b0);
        steps(7, "to2_wait", 8'h00, 1'b0, 1'b0, 2'd2, 1'b0);
        timeout_clear = 1'b1;
        step("to2_set_wins", 8'hFF, 1'b1, 1'b0, 2'd2, 1'b1);
        timeout_clear = 1'b0;
        step("to2_hold", 8'hFF, 1'b1, 1'b0, 2'd2, 1'b1);
        memory_read_n = 1'b1;
        step("to2_idle", 8'h00, 1'b1, 1'b0, 2'd2, 1'b1);

        // Reset while in DRIVE.
        source_select      = 4'b0010;
        source_wait_states = 16'h0000;
        source_ready       = 4'b0010;
        source_data[15:8]  = 8'h3C;
        memory_read_n      = 1'b0;
        step("rst_start", 8'h00, 1'b0, 1'b0, 2'd1, 1'b1);
        step("rst_drive", 8'h3C, 1'b1, 1'b0, 2'd1, 1'b1);
        reset_n = 1'b0;
        step("rst_in_drive", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
        memory_read_n = 1'b1;
        step("rst_hold", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
        reset_n = 1'b1;
        step("rst_idle", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);

        // Let the monitor drain, then confirm nothing was left unchecked.
        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
